rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//   Receiving end of the board reset/clock stimulus: turns the raw async sys_rst_n and pll_lock
//   into a clean, staged set of active-low domain resets for the afm datapath.
//   Sits in top between the pll_core instance and all downstream logic (LED driver, user cores).
//   Holds every domain in reset until the PLL has been stably locked. Releases domains in order.
//   Re-enters reset on lock loss or on a software request.
// PARAMETERS
//   LOCK_STABLE_CYCLES  1024  consecutive sampled-high pll_lock cycles required before release
//   STAGE_GAP_CYCLES    16    clk_in cycles between successive stage deassertions
//   NUM_STAGES          3     number of sequenced reset outputs (>=1)
//   SOFT_HOLD_CYCLES    64    cycles all outputs held asserted after soft_rst_req
// PORTS
//   clk_in         in   1           27 MHz reference clock (`CLOCK_FREQ_MHZ)
//   sys_rst_n      in   1           async active-low reset; assert async, deassert via 2-FF sync
//   pll_lock       in   1           PLL lock from pll_core; async to clk_in, 2-FF synchronised
//   soft_rst_req   in   1           1-cycle pulse in clk_in domain; honoured only in RUN
//   rst_n_out      out  NUM_STAGES  active-low domain resets; bit 0 released first
//   rst_done       out  1           1 while in RUN (all stages released)
//   state_o        out  3           current FSM state encoding (debug/LED)
//   lock_loss_cnt  out  8           saturating count of lock losses after release began
// BEHAVIOUR
//   Reset: sys_rst_n low -> all regs cleared asynchronously.
//   Reset values: rst_n_out = 0 (all), rst_done = 0, state_o = RESET, lock_loss_cnt = 0.
//   rst_sync: internal reset deasserts on the 2nd rising edge after sys_rst_n rises.
//   lock_s: pll_lock after 2-FF sync (reset value 0); all decisions use lock_s only.
//   FSM states and transitions; all outputs are registered:
//     RESET       -> WAIT_LOCK on the first edge after rst_sync deasserts.
//     WAIT_LOCK   lock_s=1 -> LOCK_STABLE with cnt=1. Otherwise stay.
//     LOCK_STABLE lock_s=0 -> WAIT_LOCK, cnt cleared, no count increment.
//                 cnt==LOCK_STABLE_CYCLES with lock_s=1 -> RELEASE.
//     RELEASE     entering edge T: rst_n_out[0]=1.
//                 rst_n_out[k]=1 at edge T+k*STAGE_GAP_CYCLES.
//                 Enter RUN on the edge that releases bit NUM_STAGES-1.
//                 If NUM_STAGES==1, RUN is entered at T.
//     RUN         rst_done=1 on the entering edge.
//                 soft_rst_req=1 -> SOFT_HOLD: all rst_n_out=0, rst_done=0 next edge.
//     SOFT_HOLD   hold all outputs asserted for SOFT_HOLD_CYCLES edges, then -> WAIT_LOCK.
//                 Lock is re-qualified from scratch.
//   Lock loss: lock_s=0 in RELEASE or RUN ->
//     - next edge: all rst_n_out=0, rst_done=0, state WAIT_LOCK
//     - lock_loss_cnt+1, saturating at 255
//   Lock loss in SOFT_HOLD: no count; the hold completes, then lock is re-qualified.
//   Priority in RUN: lock loss > soft_rst_req (count increments, soft request dropped).
//   soft_rst_req outside RUN is ignored (not latched).
//   Stage bits only rise in sequence order. Every asserting event drops all bits on the same edge.
//   Glitch-free: each rst_n_out bit is a flop output with no combinational path.
//   sys_rst_n low mid-sequence: every output to its reset value immediately (async).
//   The counter width is $clog2 of the larger of LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES*NUM_STAGES
//   and SOFT_HOLD_CYCLES, plus 1. It never wraps: it is cleared on every state change.
// STRUCTURE
//   common_defines.vh: `RSEQ_ST_* 3-bit state encodings (RESET=0, WAIT_LOCK=1, LOCK_STABLE=2,
//     RELEASE=3, RUN=4, SOFT_HOLD=5); `CLOCK_FREQ_MHZ already present.
//   Sub-module sync_2ff (WIDTH param, reset value 0). It is instantiated twice:
//     - reset synchroniser, D tied high
//     - pll_lock synchroniser
//   Single shared cycle counter plus next-state logic in rst_sequencer.
//   top instantiates rst_sequencer after pll_core.
// TESTING
//   Bench parameters: LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, NUM_STAGES=3, SOFT_HOLD_CYCLES=4.
//   1 Nominal: pll_lock=1 from t0, release sys_rst_n.
//     -> rst_n_out 000->001->011->111, 4 cycles apart.
//     -> rst_done=1 with bit 2; lock_loss_cnt=0.
//   2 Lock glitch while qualifying: lock drops for 1 cycle after 5 high cycles.
//     -> state back to WAIT_LOCK, no output change, count stays 0.
//     -> full 8-cycle qualification restarts.
//   3 Lock loss in RUN: pll_lock=0 for 3 cycles.
//     -> rst_n_out=000 and rst_done=0 by the 3rd edge after the pll_lock fall (2 sync + 1).
//     -> lock_loss_cnt=1; full sequence repeats after relock.
//   4 Soft reset in RUN: 1-cycle soft_rst_req.
//     -> outputs 000 next edge, held 4 cycles, then 8-cycle qualification, then staged release.
//     -> a pulse injected in WAIT_LOCK is ignored.
//   5 Simultaneous soft_rst_req and lock loss in RUN.
//     -> WAIT_LOCK (not SOFT_HOLD), lock_loss_cnt increments.
//   6 Async reset mid-RELEASE: sys_rst_n low between edges while rst_n_out=001.
//     -> all outputs 0 with no clock edge.
//     -> 260 forced lock losses saturate lock_loss_cnt at 255.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding, counter sizing,
// saturating lock-loss arithmetic.
package rst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_STABLE = 3'd2,
    ST_RELEASE     = 3'd3,
    ST_RUN         = 3'd4,
    ST_SOFT_HOLD   = 3'd5
  } rseq_state_e;

  // One shared counter must cover the longest interval any state has to time.
  function automatic int cnt_width(input int lock_cycles, input int release_span,
                                   input int hold_cycles);
    int m;
    m = lock_cycles;
    if (release_span > m) m = release_span;
    if (hold_cycles > m) m = hold_cycles;
    return $clog2(m) + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the PLL side, software and the staged domain resets.
interface rst_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  pll_lock;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] rst_n_out;
  logic                  rst_done;
  logic [2:0]            state_o;
  logic [7:0]            lock_loss_cnt;

  modport master (
    output pll_lock, soft_rst_req,
    input  rst_n_out, rst_done, state_o, lock_loss_cnt
  );

  modport slave (
    input  pll_lock, soft_rst_req,
    output rst_n_out, rst_done, state_o, lock_loss_cnt
  );
endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; clears to zero on async reset.
module rst_sequencer_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/rst_sequencer.sv
// Staged domain-reset generator: qualifies PLL lock, releases resets in order,
// and re-asserts all of them on lock loss or a software request.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int NUM_STAGES         = 3,
  parameter int SOFT_HOLD_CYCLES   = 64
) (
  input  logic          clk_in,
  input  logic          sys_rst_n,
  rst_sequencer_if.slave bus
);
  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES * NUM_STAGES,
                                SOFT_HOLD_CYCLES);

  logic                  rst_sync_n;
  logic                  lock_s;
  rseq_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic [7:0]            llc_q, llc_d;

  rst_sequencer_sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk_i (clk_in),
    .rst_ni(sys_rst_n),
    .d_i   (1'b1),
    .q_o   (rst_sync_n)
  );

  rst_sequencer_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (clk_in),
    .rst_ni(sys_rst_n),
    .d_i   (bus.pll_lock),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= {CW{1'b0}};
      rst_n_q <= {NUM_STAGES{1'b0}};
      done_q  <= 1'b0;
      llc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      llc_q   <= llc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    llc_d   = llc_q;
    case (state_q)
      ST_RESET: begin
        if (rst_sync_n) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_RESET;
        end
        cnt_d = {CW{1'b0}};
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_LOCK_STABLE;
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      ST_LOCK_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES)) begin
          cnt_d      = {CW{1'b0}};
          rst_n_d    = {NUM_STAGES{1'b0}};
          rst_n_d[0] = 1'b1;
          if (NUM_STAGES == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = {CW{1'b0}};
          rst_n_d = {NUM_STAGES{1'b0}};
          done_d  = 1'b0;
          llc_d   = sat_inc8(llc_q);
        end else begin
          // cnt_d is the distance in edges from the bit-0 release edge.
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (cnt_d == CW'(k * STAGE_GAP_CYCLES)) begin
              rst_n_d[k] = 1'b1;
            end else begin
              rst_n_d[k] = rst_n_q[k];
            end
          end
          if (cnt_d == CW'((NUM_STAGES - 1) * STAGE_GAP_CYCLES)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          rst_n_d = {NUM_STAGES{1'b0}};
          done_d  = 1'b0;
          llc_d   = sat_inc8(llc_q);
        end else if (bus.soft_rst_req) begin
          state_d = ST_SOFT_HOLD;
          rst_n_d = {NUM_STAGES{1'b0}};
          done_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
        cnt_d = {CW{1'b0}};
      end
      ST_SOFT_HOLD: begin
        if (cnt_q == CW'(SOFT_HOLD_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = {CW{1'b0}};
        rst_n_d = {NUM_STAGES{1'b0}};
        done_d  = 1'b0;
      end
    endcase
  end

  assign bus.rst_n_out     = rst_n_q;
  assign bus.rst_done      = done_q;
  assign bus.state_o       = state_q;
  assign bus.lock_loss_cnt = llc_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed scenarios plus a randomized lock/soft-request phase, checked every cycle
// against a timeline model of the staged reset release.
module tb_rst_sequencer;
  localparam int LOCK = 8;
  localparam int GAP  = 4;
  localparam int NS   = 3;
  localparam int HOLD = 4;

  logic clk_in = 1'b0;
  logic sys_rst_n;
  int   total = 0;
  int   bad   = 0;

  // Model: ages rather than states. m_qual = consecutive lock samples seen,
  // m_rel = edges since bit 0 was released, m_hold = hold edges remaining.
  int m_boot, m_qual, m_rel, m_hold, m_llc;
  bit m_s1, m_s2;

  rst_sequencer_if #(.NUM_STAGES(NS)) bus();

  rst_sequencer #(
    .LOCK_STABLE_CYCLES(LOCK),
    .STAGE_GAP_CYCLES  (GAP),
    .NUM_STAGES        (NS),
    .SOFT_HOLD_CYCLES  (HOLD)
  ) dut (
    .clk_in   (clk_in),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_boot = 0; m_qual = 0; m_rel = -1; m_hold = 0; m_llc = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  function automatic bit m_done();
    return m_rel >= (NS - 1) * GAP;
  endfunction

  function automatic int exp_state();
    if (m_boot < 3) return 0;
    if (m_hold > 0) return 5;
    if (m_rel >= 0) return m_done() ? 4 : 3;
    if (m_qual >= 1) return 2;
    return 1;
  endfunction

  function automatic logic [NS-1:0] exp_rst();
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = (m_rel >= 0) && (m_rel >= k * GAP);
    return r;
  endfunction

  task automatic m_step();
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.pll_lock;
    if (m_boot < 3) begin
      m_boot++;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_rel >= 0) begin
      if (!ls) begin
        if (m_llc < 255) m_llc++;
        m_rel = -1; m_qual = 0;
      end else if (m_done()) begin
        if (bus.soft_rst_req) begin
          m_hold = HOLD; m_rel = -1; m_qual = 0;
        end
      end else begin
        m_rel++;
      end
    end else if (m_qual >= 1) begin
      if (!ls) m_qual = 0;
      else if (m_qual == LOCK) begin m_rel = 0; m_qual = 0; end
      else m_qual++;
    end else if (ls) begin
      m_qual = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (sys_rst_n) m_step();
    #1;
    chk("rst_n_out", bus.rst_n_out, exp_rst());
    chk("rst_done", bus.rst_done, m_done());
    chk("state", bus.state_o, exp_state());
    chk("lock_loss_cnt", bus.lock_loss_cnt, m_llc);
  endtask

  task automatic run_to_run(input string tag, input int budget);
    int n = 0;
    while (exp_state() != 4 && n < budget) begin tick(); n++; end
    chk(tag, bus.state_o, 4);
  endtask

  initial begin
    int t1, t2, t3, n, llc0;
    sys_rst_n = 1'b0;
    bus.pll_lock = 1'b1;
    bus.soft_rst_req = 1'b0;
    m_reset();
    #3;
    chk("reset_rst_n_out", bus.rst_n_out, 0);
    chk("reset_done", bus.rst_done, 0);
    chk("reset_state", bus.state_o, 0);
    chk("reset_llc", bus.lock_loss_cnt, 0);
    tick(); tick();
    sys_rst_n = 1'b1;

    // 1: nominal bring-up with lock present from the start
    t1 = -1; t2 = -1; t3 = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.rst_n_out == 3'b001 && t1 < 0) t1 = i;
      if (bus.rst_n_out == 3'b011 && t2 < 0) t2 = i;
      if (bus.rst_n_out == 3'b111 && t3 < 0) begin
        t3 = i;
        chk("s1_done_with_bit2", bus.rst_done, 1);
      end
    end
    chk("s1_t001", t1, 12);
    chk("s1_t011", t2, 16);
    chk("s1_t111", t3, 20);
    chk("s1_llc", bus.lock_loss_cnt, 0);

    // 3: lock loss in RUN, three cycles low
    bus.pll_lock = 1'b0;
    tick(); tick();
    chk("s3_still_run", bus.rst_n_out, 3'b111);
    tick();
    chk("s3_out_dropped", bus.rst_n_out, 3'b000);
    chk("s3_done_dropped", bus.rst_done, 0);
    chk("s3_llc", bus.lock_loss_cnt, 1);
    bus.pll_lock = 1'b1;
    run_to_run("s3_relock", 40);

    // 4: soft reset in RUN, then an ignored pulse in WAIT_LOCK
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    chk("s4_hold_state", bus.state_o, 5);
    chk("s4_hold_out", bus.rst_n_out, 0);
    tick(); tick(); tick();
    chk("s4_hold_last", bus.state_o, 5);
    tick();
    chk("s4_wait", bus.state_o, 1);
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    chk("s4_pulse_ignored", bus.state_o, 2);
    run_to_run("s4_rerun", 40);

    // 5: soft request and lock loss land on the same edge
    llc0 = bus.lock_loss_cnt;
    bus.pll_lock = 1'b0;
    tick(); tick();
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    chk("s5_state_wait", bus.state_o, 1);
    chk("s5_llc", bus.lock_loss_cnt, llc0 + 1);

    // 2: one-cycle glitch after five high cycles during qualification
    tick(); tick(); tick();
    llc0 = bus.lock_loss_cnt;
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    tick(); tick();
    chk("s2_back_wait", bus.state_o, 1);
    chk("s2_out", bus.rst_n_out, 0);
    chk("s2_llc", bus.lock_loss_cnt, llc0);
    n = 0;
    while (bus.rst_n_out == 3'b000 && n < 30) begin tick(); n++; end
    chk("s2_requal_len", n, 9);
    run_to_run("s2_rerun", 40);

    // randomized lock drops and soft requests
    for (int i = 0; i < 1500; i++) begin
      if (!bus.pll_lock) bus.pll_lock = ($urandom_range(0, 3) != 0);
      else bus.pll_lock = ($urandom_range(0, 99) >= 3);
      bus.soft_rst_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.soft_rst_req = 1'b0;

    // 6: async reset while only bit 0 is released
    bus.pll_lock = 1'b0;
    tick(); tick(); tick();
    bus.pll_lock = 1'b1;
    n = 0;
    while (m_rel != 0 && n < 60) begin tick(); n++; end
    chk("s6_at001", bus.rst_n_out, 3'b001);
    #2;
    sys_rst_n = 1'b0;
    #1;
    m_reset();
    chk("s6_async_out", bus.rst_n_out, 0);
    chk("s6_async_done", bus.rst_done, 0);
    chk("s6_async_state", bus.state_o, 0);
    chk("s6_async_llc", bus.lock_loss_cnt, 0);
    tick();
    sys_rst_n = 1'b1;

    // 6: 260 forced lock losses saturate the counter
    for (int j = 0; j < 260; j++) begin
      n = 0;
      while (m_rel < 0 && n < 40) begin tick(); n++; end
      chk("sat_released", bus.rst_n_out[0], 1);
      bus.pll_lock = 1'b0;
      tick(); tick(); tick();
      bus.pll_lock = 1'b1;
    end
    tick();
    chk("sat_llc", bus.lock_loss_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
